tdc_capture_decoder: RTL and testbench

//   Receive end of the TDC delay line. Samples the N-tap thermometer word

---
 rtl/tdc_capture_decoder_if.sv | 28 ++
 rtl/tdc_capture_decoder.sv | 107 ++++++++++
 tb/tb_tdc_capture_decoder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/tdc_capture_decoder_if.sv
// Measurement result channel between the TDC capture decoder and the readout logic.
interface tdc_capture_decoder_if #(
  parameter int unsigned W = 6
);
  logic         meas_valid;
  logic         meas_ready;
  logic [W-1:0] meas_code;
  logic         meas_bubble;
  logic         meas_overflow;

  // Producer side: the capture decoder.
  modport master (
    output meas_valid,
    output meas_code,
    output meas_bubble,
    output meas_overflow,
    input  meas_ready
  );

  // Consumer side: the readout logic.
  modport slave (
    input  meas_valid,
    input  meas_code,
    input  meas_bubble,
    input  meas_overflow,
    output meas_ready
  );
endinterface

// File: rtl/tdc_capture_decoder.sv
// TDC receive end: samples the delay-line thermometer word one edge after arm,
// passes it through two flop stages, decodes it to a tap count with bubble and
// overflow flags, and holds the result on a valid/ready channel.
module tdc_capture_decoder #(
  parameter int unsigned N = 32,
  parameter int unsigned W = $clog2(N + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arm,
  input  logic [N-1:0]          dl_in,
  output logic                  busy,
  tdc_capture_decoder_if.master meas
);

  typedef enum logic [2:0] {
    StIdle,
    StCap1,
    StCap2,
    StDec,
    StHold
  } state_e;

  state_e         state_q;
  logic [N-1:0]   s1_q, s2_q;
  logic           busy_q;
  logic           valid_q;
  logic [W-1:0]   code_q;
  logic           bubble_q;
  logic           overflow_q;

  logic [W-1:0]   code_d;
  logic           bubble_d;
  logic           overflow_d;

  // Free-running two-stage synchroniser; the FSM picks which sample matters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= dl_in;
      s2_q <= s1_q;
    end
  end

  // Decode of the synchronised word: popcount is inherently bubble tolerant;
  // a 1 above a 0 survives the +1 carry and shows up in the AND.
  always_comb begin
    code_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      code_d = code_d + W'(s2_q[i]);
    end
    bubble_d   = |(s2_q & (s2_q + N'(1)));
    overflow_d = &s2_q;
  end

  // Measurement sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      code_q     <= '0;
      bubble_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arm) begin
            state_q <= StCap1;
            busy_q  <= 1'b1;
          end
        end
        StCap1: state_q <= StCap2;
        StCap2: state_q <= StDec;
        StDec: begin
          code_q     <= code_d;
          bubble_q   <= bubble_d;
          overflow_q <= overflow_d;
          valid_q    <= 1'b1;
          state_q    <= StHold;
        end
        StHold: begin
          // An arm on this same edge is dropped: busy is still high here.
          if (meas.meas_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy               = busy_q;
  assign meas.meas_valid    = valid_q;
  assign meas.meas_code     = code_q;
  assign meas.meas_bubble   = bubble_q;
  assign meas.meas_overflow = overflow_q;

endmodule

// File: tb/tb_tdc_capture_decoder.sv
// Directed bench for tdc_capture_decoder: reset, decode patterns, backpressure,
// arm-while-busy and back-to-back measurements.
module tb_tdc_capture_decoder;
  localparam int unsigned N = 32;
  localparam int unsigned W = 6;

  logic         clk;
  logic         rst_n;
  logic         arm;
  logic [N-1:0] dl_in;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  tdc_capture_decoder_if #(.W(W)) meas_if ();

  tdc_capture_decoder #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arm   (arm),
    .dl_in (dl_in),
    .busy  (busy),
    .meas  (meas_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Arm with a held word and walk to the edge where meas_valid must rise.
  task automatic measure(input logic [N-1:0] word);
    dl_in = word;
    arm   = 1'b1;
    step();                       // E0
    arm = 1'b0;
    check_eq("busy_after_e0", 32'(busy), 32'd1);
    step();                       // E1
    check_eq("valid_e1", 32'(meas_if.meas_valid), 32'd0);
    step();                       // E2
    check_eq("valid_e2", 32'(meas_if.meas_valid), 32'd0);
    step();                       // E3
    check_eq("valid_e3", 32'(meas_if.meas_valid), 32'd1);
  endtask

  task automatic expect_result(input string tag, input int code, input bit bub, input bit ovf);
    check_eq({tag, "_code"}, 32'(meas_if.meas_code), 32'(code));
    check_eq({tag, "_bubble"}, 32'(meas_if.meas_bubble), 32'(bub));
    check_eq({tag, "_overflow"}, 32'(meas_if.meas_overflow), 32'(ovf));
  endtask

  task automatic handshake();
    meas_if.meas_ready = 1'b1;
    step();
    meas_if.meas_ready = 1'b0;
    check_eq("hs_valid", 32'(meas_if.meas_valid), 32'd0);
    check_eq("hs_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    arm   = 1'b0;
    dl_in = '0;
    meas_if.meas_ready = 1'b0;
    #12;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_valid", 32'(meas_if.meas_valid), 32'd0);
    expect_result("rst", 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();

    // Clean thermometer of 8 taps, then reset while holding it.
    measure(32'h0000_00FF);
    expect_result("ff", 8, 1'b0, 1'b0);
    step();
    check_eq("hold_valid", 32'(meas_if.meas_valid), 32'd1);
    rst_n = 1'b0;
    #2;   // well before the next rising edge
    check_eq("midrst_valid", 32'(meas_if.meas_valid), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_code", 32'(meas_if.meas_code), 32'd0);
    rst_n = 1'b1;
    step();
    check_eq("postrst_busy", 32'(busy), 32'd0);
    check_eq("postrst_valid", 32'(meas_if.meas_valid), 32'd0);

    // Bubble, empty and full-line words.
    measure(32'h0000_00F7);
    expect_result("f7", 7, 1'b1, 1'b0);
    handshake();
    check_eq("f7_code_kept", 32'(meas_if.meas_code), 32'd7);
    measure(32'h0000_0000);
    expect_result("zero", 0, 1'b0, 1'b0);
    handshake();
    measure(32'hFFFF_FFFF);
    expect_result("full", 32, 1'b0, 1'b1);
    handshake();

    // Backpressure with toggling taps and ignored arms.
    measure(32'h0000_000F);
    for (int i = 0; i < 5; i++) begin
      dl_in = $urandom();
      arm   = (i % 2 == 0);
      step();
      check_eq("bp_valid", 32'(meas_if.meas_valid), 32'd1);
      check_eq("bp_busy", 32'(busy), 32'd1);
      expect_result("bp", 4, 1'b0, 1'b0);
    end
    arm = 1'b0;
    handshake();
    check_eq("bp_code_kept", 32'(meas_if.meas_code), 32'd4);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("bp_no_queued", 32'(busy), 32'd0);
    end

    // Arm on the handshake edge itself is dropped.
    measure(32'h0000_0001);
    expect_result("one", 1, 1'b0, 1'b0);
    arm = 1'b1;
    handshake();
    arm = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("hs_arm_busy", 32'(busy), 32'd0);
      check_eq("hs_arm_valid", 32'(meas_if.meas_valid), 32'd0);
    end

    // Back-to-back: arm in the first IDLE cycle after a handshake.
    measure(32'h0000_0007);
    expect_result("seven", 3, 1'b0, 1'b0);
    handshake();
    measure(32'h0000_0003);
    expect_result("b2b", 2, 1'b0, 1'b0);
    handshake();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
